// File: rtl/rv32i_memory_pkg.sv
// Shared types and constants for the fetch/execute memory responder and its arbiter.
package rv32i_memory_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;
    typedef enum logic {INSTR = 1'b0, DATA = 1'b1} port_t;

    localparam int WORD_BYTES    = 4;
    localparam int BYTE_LANES    = 4;
    localparam int ADDRESS_WIDTH = 32;
endpackage

// File: rtl/memory_round_robin_arbiter.sv
// Two-way round-robin arbiter: request/grant bit 0 is the fetch port, bit 1 the data port.
module memory_round_robin_arbiter
    import rv32i_memory_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] request,
    input  logic       accept,
    output logic [1:0] grant
);
    port_t last_grant;

    always_comb begin
        grant = 2'b00;
        case (request)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == INSTR) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= INSTR;
        end else if (accept) begin
            last_grant <= grant[1] ? DATA : INSTR;
        end
    end
endmodule

// File: rtl/memory_responder.sv
// Single-ported word memory serving fetch and load/store requests with a fixed
// accept-to-response latency and one-cycle response pulses.
module memory_responder
    import rv32i_memory_pkg::*;
#(
    parameter int    DEPTH     = 1024,
    parameter int    LATENCY   = 1,
    parameter string INIT_FILE = ""
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        instruction_read_enable,
    input  logic [31:0] instruction_read_address,
    output logic        instruction_read_ready,
    output logic        instruction_read_valid,
    output logic [31:0] instruction_read_value,
    input  logic        data_read_enable,
    input  logic        data_write_enable,
    input  logic [31:0] data_address,
    input  logic [31:0] data_write_value,
    input  logic [3:0]  data_byte_enable,
    output logic        data_ready,
    output logic        data_read_valid,
    output logic [31:0] data_read_value,
    output logic        data_write_done,
    output logic        access_error
);
    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [31:0] mem [DEPTH];

    logic [1:0]       request;
    logic [1:0]       grant;
    logic             accept;
    logic             idle;
    logic [31:0]      acc_addr;
    logic [IDX_W-1:0] acc_idx;
    logic             acc_err;
    logic             acc_is_data;
    logic             acc_rd;
    logic             acc_wr;
    logic [31:0]      acc_rdata;

    logic        is_data_p0;
    logic        rd_p0;
    logic        wr_p0;
    logic        err_p0;
    logic [31:0] rdata_p0;

    logic        go_respond;
    logic        rsp_is_data;
    logic        rsp_rd;
    logic        rsp_wr;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    memory_round_robin_arbiter u_arbiter (
        .clock   (clock),
        .reset   (reset),
        .request (request),
        .accept  (accept),
        .grant   (grant)
    );

    assign idle    = (state == IDLE) && !reset;
    assign request = {data_read_enable | data_write_enable, instruction_read_enable};

    assign instruction_read_ready = idle & grant[0];
    assign data_ready             = idle & grant[1];
    assign accept                 = instruction_read_ready | data_ready;

    assign acc_is_data = grant[1];
    assign acc_addr    = acc_is_data ? data_address : instruction_read_address;
    assign acc_idx     = acc_addr[IDX_W+1:2];
    // Any address bits above the index also count, so aliases beyond DEPTH are errors.
    assign acc_err     = (acc_addr[1:0] != 2'b00) || ({2'b00, acc_addr[31:2]} >= 32'(DEPTH));
    assign acc_rd      = acc_is_data ? data_read_enable : 1'b1;
    assign acc_wr      = acc_is_data & data_write_enable;
    assign acc_rdata   = (acc_err || !acc_rd) ? 32'd0 : mem[acc_idx];

    // Accept stage: array access and request capture
    always_ff @(posedge clock) begin
        if (accept) begin
            is_data_p0 <= acc_is_data;
            rd_p0      <= acc_rd;
            wr_p0      <= acc_wr;
            err_p0     <= acc_err;
            rdata_p0   <= acc_rdata;
            if (acc_wr && !acc_err) begin
                for (int lane = 0; lane < BYTE_LANES; lane++) begin
                    if (data_byte_enable[lane]) begin
                        mem[acc_idx][8*lane +: 8] <= data_write_value[8*lane +: 8];
                    end
                end
            end
        end
    end

    // With LATENCY=1 the response is formed from the request being accepted right now.
    assign go_respond  = (state == IDLE) ? (accept && (LATENCY == 1))
                                         : ((state == WAIT) && (wait_cnt == 4'd0));
    assign rsp_is_data = (state == IDLE) ? acc_is_data : is_data_p0;
    assign rsp_rd      = (state == IDLE) ? acc_rd      : rd_p0;
    assign rsp_wr      = (state == IDLE) ? acc_wr      : wr_p0;
    assign rsp_err     = (state == IDLE) ? acc_err     : err_p0;
    assign rsp_rdata   = (state == IDLE) ? acc_rdata   : rdata_p0;

    // Response stage: sequencing and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state                  <= IDLE;
            wait_cnt               <= 4'd0;
            instruction_read_valid <= 1'b0;
            instruction_read_value <= 32'd0;
            data_read_valid        <= 1'b0;
            data_read_value        <= 32'd0;
            data_write_done        <= 1'b0;
            access_error           <= 1'b0;
        end else begin
            instruction_read_valid <= 1'b0;
            data_read_valid        <= 1'b0;
            data_write_done        <= 1'b0;
            access_error           <= 1'b0;
            if (go_respond) begin
                state                  <= RESPOND;
                instruction_read_valid <= !rsp_is_data;
                data_read_valid        <= rsp_is_data & rsp_rd;
                data_write_done        <= rsp_is_data & rsp_wr;
                access_error           <= rsp_err;
                if (rsp_is_data) begin
                    data_read_value <= rsp_rdata;
                end else begin
                    instruction_read_value <= rsp_rdata;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                    WAIT:    wait_cnt <= wait_cnt - 4'd1;
                    RESPOND: state    <= IDLE;
                    default: state    <= IDLE;
                endcase
            end
        end
    end
endmodule
